// File: rtl/tdc_pkg.sv
// Shared definitions for the multi-channel time-to-digital converter:
// parameter defaults, FSM state encoding and the timeout result code.
package tdc_pkg;

  localparam int NCH_DEF         = 4;
  localparam int CNT_W_DEF       = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_MAX       = 32;

  // All-ones doubles as the saturated counter value and the "no stop seen" result.
  localparam logic [CNT_W_MAX-1:0] TIMEOUT_CODE = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

endpackage

// File: rtl/tdc_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by a
// rising/falling edge detector. Every input sees the same latency.
module tdc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic rxclk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge rxclk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/tdc_multi_ch.sv
// Multi-channel TDC: one start, NCH stops, shared coarse counter, results
// streamed out in channel order over a valid/ready handshake.
//   state   | meaning
//   IDLE    | disabled, waiting for TDC_en
//   ARMED   | waiting for a start edge on trigin
//   MEASURE | counter running, channels capturing stop edges
//   READOUT | presenting one result per channel, ascending order
module tdc_multi_ch
  import tdc_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             rxclk,
  input  logic             rst,
  input  logic             TDC_en,
  input  logic             mode,
  input  logic             trigin,
  input  logic [NCH-1:0]   stop_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CH_W-1:0]  res_chan,
  output logic [CNT_W-1:0] res_data,
  output logic             res_timeout,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = TIMEOUT_CODE[CNT_W-1:0];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] val_q [NCH];
  logic [CNT_W-1:0] val_d [NCH];
  logic [NCH-1:0]   cmp_q, cmp_d;
  logic [NCH-1:0]   started_q, started_d;
  logic [CH_W-1:0]  idx_q, idx_d;
  logic             done_q, done_d;

  logic           trig_rise;
  logic           unused_trig_fall;
  logic [NCH-1:0] stop_rise, stop_fall;

  tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_trig (
    .rxclk(rxclk), .rst(rst), .async_in(trigin),
    .rise(trig_rise), .fall(unused_trig_fall)
  );

  for (genvar g = 0; g < NCH; g++) begin : g_stop
    tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stop (
      .rxclk(rxclk), .rst(rst), .async_in(stop_in[g]),
      .rise(stop_rise[g]), .fall(stop_fall[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    val_d     = val_q;
    cmp_d     = cmp_q;
    started_d = started_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (TDC_en) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!TDC_en) begin
          state_d = ST_IDLE;
        end else if (trig_rise) begin
          state_d   = ST_MEASURE;
          mode_d    = mode;
          cnt_d     = CNT_W'(1);
          cmp_d     = '0;
          started_d = '0;
          for (int i = 0; i < NCH; i++) val_d[i] = '0;
        end
      end
      ST_MEASURE: begin
        if (!TDC_en) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          for (int i = 0; i < NCH; i++) begin
            if (!cmp_q[i]) begin
              if (!mode_q) begin
                if (stop_rise[i]) begin
                  val_d[i] = cnt_q;
                  cmp_d[i] = 1'b1;
                end
              end else if (!started_q[i]) begin
                if (stop_rise[i]) begin
                  val_d[i]     = cnt_q;
                  started_d[i] = 1'b1;
                end
              end else if (stop_fall[i]) begin
                val_d[i] = cnt_q - val_q[i];
                cmp_d[i] = 1'b1;
              end
            end
          end
          // Captures made in the saturating cycle still count.
          if ((&cmp_d) || (cnt_q == CNT_MAX)) begin
            state_d = ST_READOUT;
            idx_d   = '0;
          end
        end
      end
      ST_READOUT: begin
        if (res_ready) begin
          if (idx_q == CH_W'(NCH - 1)) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = TDC_en ? ST_ARMED : ST_IDLE;
          end else begin
            idx_d = idx_q + CH_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rxclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      cmp_q     <= '0;
      started_q <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) val_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      cmp_q     <= cmp_d;
      started_q <= started_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      for (int i = 0; i < NCH; i++) val_q[i] <= val_d[i];
    end
  end

  always_comb begin
    res_valid   = (state_q == ST_READOUT);
    res_chan    = idx_q;
    res_data    = '0;
    res_timeout = 1'b0;
    if (res_valid) begin
      res_data    = cmp_q[idx_q] ? val_q[idx_q] : CNT_MAX;
      res_timeout = ~cmp_q[idx_q];
    end
    busy = (state_q != ST_IDLE);
    done = done_q;
  end

endmodule

// File: tb/tb_tdc_multi_ch.sv
// Directed, table-driven bench for tdc_multi_ch (NCH=4, CNT_W=16, SYNC_STAGES=2).
module tb_tdc_multi_ch;

  localparam int NCH   = 4;
  localparam int CNT_W = 16;

  logic             rxclk = 1'b0;
  logic             rst, TDC_en, mode, trigin, res_ready;
  logic [NCH-1:0]   stop_in;
  logic             res_valid, res_timeout, busy, done;
  logic [1:0]       res_chan;
  logic [CNT_W-1:0] res_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 rxclk = ~rxclk;

  tdc_multi_ch #(.NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .rxclk(rxclk), .rst(rst), .TDC_en(TDC_en), .mode(mode), .trigin(trigin),
    .stop_in(stop_in), .res_valid(res_valid), .res_ready(res_ready),
    .res_chan(res_chan), .res_data(res_data), .res_timeout(res_timeout),
    .busy(busy), .done(done)
  );

  // r: stop rise offset after trigin rise (0 = never); w: high width (0 = stays high)
  typedef struct {
    logic             md;
    logic [3:0][15:0] r;
    logic [3:0][15:0] w;
    int               stall;
    logic             end_en;
    logic [3:0][15:0] exp_d;
    logic [3:0]       exp_to;
  } vec_t;

  vec_t vecs [5];

  task automatic step(input int n);
    repeat (n) @(posedge rxclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic measure(input vec_t v);
    bit got;
    logic [3:0] s;
    TDC_en = 1'b1;
    mode   = v.md;
    step(3);
    check("armed_busy", 32'(busy), 32'd1);
    check("armed_no_valid", 32'(res_valid), 32'd0);
    trigin = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 70000 && !got; t++) begin
      for (int i = 0; i < 4; i++) begin
        int ri, wi;
        ri = int'(v.r[i]);
        wi = int'(v.w[i]);
        s[i] = (ri != 0) && (t >= ri) && (wi == 0 || t < ri + wi);
      end
      stop_in = s;
      if (t == 4) trigin = 1'b0;
      step(1);
      if (res_valid) got = 1'b1;
    end
    check("reach_readout", 32'(got), 32'd1);
    stop_in = '0;
    trigin  = 1'b0;
  endtask

  task automatic readout(input vec_t v);
    if (!v.end_en) TDC_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s <= v.stall; s++) begin
        res_ready = (s == v.stall);
        check("rd_valid", 32'(res_valid), 32'd1);
        check("rd_chan", 32'(res_chan), 32'(k));
        check("rd_data", 32'(res_data), 32'(v.exp_d[k]));
        check("rd_timeout", 32'(res_timeout), 32'(v.exp_to[k]));
        check("rd_no_done", 32'(done), 32'd0);
        step(1);
      end
    end
    res_ready = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("post_busy", 32'(busy), 32'(v.end_en));
    check("post_valid", 32'(res_valid), 32'd0);
    step(1);
    check("done_one_cycle", 32'(done), 32'd0);
    step(4);
  endtask

  initial begin
    rst = 1'b1; TDC_en = 1'b0; mode = 1'b0; trigin = 1'b0;
    stop_in = '0; res_ready = 1'b0;
    step(3);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_chan", 32'(res_chan), 32'd0);
    check("rst_data", 32'(res_data), 32'd0);
    check("rst_timeout", 32'(res_timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    trigin = 1'b1;
    step(4);
    check("idle_ignores_trig", 32'(busy), 32'd0);
    trigin = 1'b0;
    step(4);

    // vector fields are written {ch3, ch2, ch1, ch0}
    vecs[0] = '{md: 1'b0, r: {16'd40, 16'd3, 16'd12, 16'd5}, w: '0, stall: 0, end_en: 1'b1,
                exp_d: {16'd40, 16'd3, 16'd12, 16'd5}, exp_to: 4'b0000};
    vecs[1] = '{md: 1'b1, r: {16'd5, 16'd4, 16'd3, 16'd2}, w: {16'd1, 16'd1, 16'd17, 16'd1},
                stall: 0, end_en: 1'b1, exp_d: {16'd1, 16'd1, 16'd17, 16'd1}, exp_to: 4'b0000};
    vecs[2] = '{md: 1'b1, r: {16'd1, 16'd6, 16'd5, 16'd2}, w: {16'd8, 16'd4, 16'd2, 16'd3},
                stall: 0, end_en: 1'b1, exp_d: {16'd8, 16'd4, 16'd2, 16'd3}, exp_to: 4'b0000};
    vecs[3] = '{md: 1'b0, r: {16'd1, 16'd9, 16'd2, 16'd7}, w: '0, stall: 10, end_en: 1'b0,
                exp_d: {16'd1, 16'd9, 16'd2, 16'd7}, exp_to: 4'b0000};
    vecs[4] = '{md: 1'b0, r: {16'd40, 16'd0, 16'd12, 16'd5}, w: '0, stall: 0, end_en: 1'b0,
                exp_d: {16'd40, 16'hFFFF, 16'd12, 16'd5}, exp_to: 4'b0100};

    for (int i = 0; i < 5; i++) begin
      measure(vecs[i]);
      readout(vecs[i]);
    end

    // abort in MEASURE
    TDC_en = 1'b1; mode = 1'b0;
    step(3);
    trigin = 1'b1;
    step(6);
    trigin = 1'b0;
    check("abort_pre_busy", 32'(busy), 32'd1);
    TDC_en = 1'b0;
    step(1);
    check("abort_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("abort_no_valid", 32'(res_valid), 32'd0);
      check("abort_no_done", 32'(done), 32'd0);
      step(1);
    end

    // reset in the middle of READOUT
    measure(vecs[0]);
    res_ready = 1'b1;
    step(2);
    res_ready = 1'b0;
    check("pre_rst_chan", 32'(res_chan), 32'd2);
    check("pre_rst_data", 32'(res_data), 32'd3);
    rst = 1'b1;
    step(1);
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_chan", 32'(res_chan), 32'd0);
    check("mid_rst_data", 32'(res_data), 32'd0);
    check("mid_rst_timeout", 32'(res_timeout), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    TDC_en = 1'b0;
    step(2);
    check("post_rst_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdc_multi_ch.md
TDC_MULTI_CH -- requirements
Module: tdc_multi_ch

Interface
REQ-001 SHALL have parameter NCH, default 4, number of stop channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, coarse counter/result width (8..32).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth per asynchronous input (2..4).
REQ-004 SHALL have port rxclk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port TDC_en, input, 1, arm/enable level.
REQ-007 SHALL have port mode, input, 1: 0 = start-to-stop interval, 1 = stop pulse high width.
REQ-008 SHALL have port trigin, input, 1, asynchronous start.
REQ-009 SHALL have port stop_in, input, NCH, asynchronous per-channel stop.
REQ-010 SHALL have port res_valid, output, 1, result available.
REQ-011 SHALL have port res_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port res_chan, output, clog2(NCH) (min 1), channel index of result.
REQ-013 SHALL have port res_data, output, CNT_W, measured count in rxclk periods.
REQ-014 SHALL have port res_timeout, output, 1, channel did not complete.
REQ-015 SHALL have port busy, output, 1, high in ARMED, MEASURE and READOUT.
REQ-016 SHALL have port done, output, 1, one-cycle pulse after last result accepted.

Function
REQ-017 SHALL pass trigin and each stop_in through SYNC_STAGES flops then a rising/falling edge detector; equal latency on all inputs.
REQ-018 SHALL implement FSM IDLE, ARMED, MEASURE, READOUT.
REQ-019 IDLE: TDC_en=1 -> ARMED next cycle.
REQ-020 ARMED: synced trigin rising edge -> MEASURE, mode latched that cycle; TDC_en=0 -> IDLE.
REQ-021 MEASURE: shared counter = 1 in first MEASURE cycle, +1 per cycle; saturates at 2^CNT_W-1, never wraps.
REQ-022 Mode 0: channel captures counter at its first synced stop rising edge in MEASURE; later edges ignored; an edge in the start-edge cycle is ignored.
REQ-023 Mode 1: channel stores counter at first rising edge, result = counter at next falling edge minus stored value; a falling edge without prior rise is ignored.
REQ-024 Rising and falling edges on different channels in the same cycle SHALL be handled independently.
REQ-025 MEASURE -> READOUT when all channels complete or counter reaches 2^CNT_W-1, whichever first.
REQ-026 Incomplete channels SHALL report res_data all ones, res_timeout=1.
REQ-027 READOUT: channels presented in ascending order 0..NCH-1; res_valid, res_chan, res_data, res_timeout held stable until res_valid&res_ready; advance one channel per handshake, zero bubble.
REQ-028 After last handshake: done=1 for one cycle; next state ARMED if TDC_en=1, else IDLE.
REQ-029 TDC_en=0 in MEASURE SHALL abort to IDLE next cycle, no results, no done.
REQ-030 TDC_en=0 in READOUT SHALL NOT abort; readout completes, then IDLE.
REQ-031 trigin edges outside ARMED SHALL be ignored.

Reset
REQ-032 rst=1 SHALL force IDLE, counter 0, all channel state and synchronizer flops 0, res_valid=0, res_chan=0, res_data=0, res_timeout=0, busy=0, done=0, next edge.
REQ-033 rst SHALL take priority over all other inputs, including mid-MEASURE and mid-READOUT.

Structure
REQ-034 Shared package tdc_pkg SHALL hold the FSM state type, parameter defaults, and the timeout code (all-ones) definition.
REQ-035 Sub-module tdc_sync_edge (SYNC_STAGES synchronizer plus rise/fall detect) SHALL be instantiated once per trigin and per stop_in bit.

Verification (NCH=4, CNT_W=16, SYNC_STAGES=2)
REQ-036 Mode 0: start, stops ch0..3 at +5,+12,+3,+40 cycles -> results ch0=5, ch1=12, ch2=3, ch3=40, timeout=0, then done pulse.
REQ-037 Mode 1: ch1 high 17 cycles, others high 1 cycle -> ch1=17, others=1.
REQ-038 Timeout: ch2 never stops -> ch2 res_data=16'hFFFF, res_timeout=1 after 65535 counts; others correct.
REQ-039 Backpressure: res_ready low 10 cycles per result -> outputs stable while stalled, order 0..3, exactly 4 handshakes.
REQ-040 Abort/reset: TDC_en=0 mid-MEASURE -> IDLE, no res_valid; rst mid-READOUT -> all outputs 0 next cycle.
